// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings and checker state encoding
package alu_pkg;

  // Arithmetic and logic encodings share the same two Oper bits; Mode selects the meaning.
  localparam logic [1:0] OP_TRANSFER = 2'b00;
  localparam logic [1:0] OP_ADD      = 2'b01;
  localparam logic [1:0] OP_SUB_AB   = 2'b10;
  localparam logic [1:0] OP_SUB_BA   = 2'b11;
  localparam logic [1:0] OP_AND      = 2'b00;
  localparam logic [1:0] OP_OR       = 2'b01;
  localparam logic [1:0] OP_XOR      = 2'b10;
  localparam logic [1:0] OP_XNOR     = 2'b11;

  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_LOGIC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational reference ALU producing expected sum and carry-out
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [1:0]   Oper,
  input  logic         Mode,
  output logic [N-1:0] exp_sum,
  output logic         exp_cout
);

  always_comb begin
    exp_sum  = '0;
    exp_cout = 1'b0;
    if (Mode == MODE_ARITH) begin
      case (Oper)
        OP_TRANSFER: exp_sum = A;
        OP_ADD:      {exp_cout, exp_sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
        OP_SUB_AB: begin
          exp_sum  = A - B;
          exp_cout = (A < B);
        end
        OP_SUB_BA: begin
          exp_sum  = B - A;
          exp_cout = (B < A);
        end
        default: ;
      endcase
    end else begin
      case (Oper)
        OP_AND:  exp_sum = A & B;
        OP_OR:   exp_sum = A | B;
        OP_XOR:  exp_sum = A ^ B;
        OP_XNOR: exp_sum = ~(A ^ B);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - snoops ALU issues, aligns golden results to ALU latency, scores them
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 1,
  parameter int CW  = 16
) (
  input  logic            Clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            issue_valid,
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic            Cin,
  input  logic [1:0]      Oper,
  input  logic            Mode,
  input  logic [N-1:0]    Sum,
  input  logic            Cout,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   pass_cnt,
  output logic [CW-1:0]   fail_cnt,
  output logic            fail_flag,
  output logic [2*N+2:0]  fail_info,
  output logic [N+1:0]    fail_obs
);

  typedef struct packed {
    logic         valid;
    logic         mode;
    logic [1:0]   oper;
    logic [N-1:0] sum;
    logic         cout;
  } entry_t;

  chk_state_t   state, state_nxt;
  entry_t       pipe [LAT];
  entry_t       head;
  logic [N-1:0] gold_sum;
  logic         gold_cout;
  logic         load, clear, inflight, match;

  alu_golden_model #(.N(N)) u_golden (
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Oper     (Oper),
    .Mode     (Mode),
    .exp_sum  (gold_sum),
    .exp_cout (gold_cout)
  );

  assign head  = pipe[LAT-1];
  assign load  = issue_valid && (state == ST_RUN);
  assign clear = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign match = (Sum == head.sum) && (Cout == head.cout);

  // Entries that will still be in flight after this edge; the head retires on this edge.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < LAT - 1; i++) inflight = inflight | pipe[i].valid;
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: load, mode: Mode, oper: Oper, sum: gold_sum, cout: gold_cout};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_flag <= 1'b0;
      fail_info <= '0;
      fail_obs  <= '0;
    end else if (clear) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_flag <= 1'b0;
      fail_info <= '0;
      fail_obs  <= '0;
    end else if (head.valid) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CW'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
        fail_flag <= 1'b1;
        // Upper N bits of fail_info are unused and stay zero.
        if (!fail_flag) begin
          fail_info <= {{N{1'b0}}, head.mode, head.oper, head.sum};
          fail_obs  <= {head.cout, Cout, Sum};
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!inflight) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - directed self-checking bench for alu_result_checker (LAT=1 and LAT=3)
module tb_alu_result_checker;

  logic        Clk = 1'b0;
  logic        rst;
  logic        start1, stop1, iv1, start3, stop3, iv3;
  logic [3:0]  A, B;
  logic        Cin, Mode;
  logic [1:0]  Oper;
  logic [3:0]  Sum1, Sum3;
  logic        Cout1, Cout3;

  logic        busy1, done1, flag1, busy3, done3, flag3;
  logic [15:0] pass1, fail1;
  logic [2:0]  pass3, fail3;
  logic [10:0] info1, info3;
  logic [5:0]  obs1, obs3;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] d3s [3];
  logic       d3c [3];
  logic [3:0] r_sum;
  logic       r_cout;

  logic [3:0] ta [6];
  logic [3:0] tb [6];
  logic       tc [6];
  logic [3:0] ts [6];
  logic       tco [6];

  always #5 Clk = ~Clk;

  alu_result_checker #(.N(4), .LAT(1), .CW(16)) dut1 (
    .Clk(Clk), .rst(rst), .start(start1), .stop(stop1), .issue_valid(iv1),
    .A(A), .B(B), .Cin(Cin), .Oper(Oper), .Mode(Mode), .Sum(Sum1), .Cout(Cout1),
    .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
    .fail_flag(flag1), .fail_info(info1), .fail_obs(obs1)
  );

  alu_result_checker #(.N(4), .LAT(3), .CW(3)) dut3 (
    .Clk(Clk), .rst(rst), .start(start3), .stop(stop3), .issue_valid(iv3),
    .A(A), .B(B), .Cin(Cin), .Oper(Oper), .Mode(Mode), .Sum(Sum3), .Cout(Cout3),
    .busy(busy3), .done(done3), .pass_cnt(pass3), .fail_cnt(fail3),
    .fail_flag(flag3), .fail_info(info3), .fail_obs(obs3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the LAT=3 response model delays r_sum/r_cout by three edges.
  task automatic tick();
    @(posedge Clk);
    #1;
    d3s[2] = d3s[1]; d3s[1] = d3s[0]; d3s[0] = r_sum;
    d3c[2] = d3c[1]; d3c[1] = d3c[0]; d3c[0] = r_cout;
    Sum3 = d3s[2]; Cout3 = d3c[2];
    r_sum = 4'd0; r_cout = 1'b0;
  endtask

  task automatic op1(input logic m, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [3:0] rs, input logic rc);
    Mode = m; Oper = o; A = a; B = b; Cin = c; iv1 = 1'b1;
    tick();
    iv1 = 1'b0; Sum1 = rs; Cout1 = rc;
    tick();
  endtask

  initial begin
    rst = 1'b1; start1 = 0; stop1 = 0; iv1 = 0; start3 = 0; stop3 = 0; iv3 = 0;
    A = 0; B = 0; Cin = 0; Mode = 0; Oper = 0; Sum1 = 0; Cout1 = 0; Sum3 = 0; Cout3 = 0;
    r_sum = 0; r_cout = 0;
    for (int i = 0; i < 3; i++) begin d3s[i] = 0; d3c[i] = 0; end
    ta = '{4'd1, 4'd2, 4'd15, 4'd7, 4'd5, 4'd12};
    tb = '{4'd2, 4'd3, 4'd1,  4'd8, 4'd5, 4'd3};
    tc = '{1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0};
    ts = '{4'd3, 4'd6, 4'd0,  4'd0, 4'd10, 4'd15};
    tco = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    tick(); tick();
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_fail", 32'(fail1), 0);
    chk("rst_flag", 32'(flag1), 0);
    chk("rst_info", 32'(info1), 0);
    chk("rst_obs", 32'(obs1), 0);
    rst = 1'b0;
    tick();

    start1 = 1; tick(); start1 = 0;
    chk("start_busy", 32'(busy1), 1);
    op1(1'b1, 2'b01, 4'd10, 4'd5, 1'b1, 4'd0, 1'b1);
    chk("add_pass", 32'(pass1), 1);
    chk("add_flag", 32'(flag1), 0);
    op1(1'b1, 2'b10, 4'd2, 4'd5, 1'b0, 4'd13, 1'b0);
    chk("sub_fail", 32'(fail1), 1);
    chk("sub_flag", 32'(flag1), 1);
    chk("sub_obs", 32'(obs1), 32'h2D);
    chk("sub_info", 32'(info1), 32'h06D);
    op1(1'b0, 2'b00, 4'd8, 4'd11, 1'b0, 4'd8, 1'b0);
    op1(1'b0, 2'b01, 4'd8, 4'd11, 1'b0, 4'd11, 1'b0);
    op1(1'b0, 2'b10, 4'd8, 4'd11, 1'b0, 4'd3, 1'b0);
    op1(1'b0, 2'b11, 4'd8, 4'd11, 1'b0, 4'd12, 1'b0);
    chk("logic_pass", 32'(pass1), 5);
    chk("logic_fail", 32'(fail1), 1);
    chk("logic_obs_hold", 32'(obs1), 32'h2D);

    stop1 = 1; tick(); stop1 = 0;
    chk("drain_busy", 32'(busy1), 1);
    tick();
    chk("done1", 32'(done1), 1);
    chk("done_pass_hold", 32'(pass1), 5);

    start1 = 1; stop1 = 1; tick(); start1 = 0; stop1 = 0;
    chk("restart_busy", 32'(busy1), 1);
    chk("restart_pass", 32'(pass1), 0);
    chk("restart_flag", 32'(flag1), 0);
    op1(1'b0, 2'b00, 4'd3, 4'd5, 1'b0, 4'd7, 1'b0);
    op1(1'b1, 2'b11, 4'd3, 4'd5, 1'b0, 4'd9, 1'b1);
    chk("two_fail_cnt", 32'(fail1), 2);
    chk("two_fail_info", 32'(info1), 32'h001);
    chk("two_fail_obs", 32'(obs1), 32'h07);

    Mode = 1; Oper = 2'b01; A = 4'd1; B = 4'd1; Cin = 0; iv1 = 1; stop1 = 1;
    tick();
    iv1 = 0; stop1 = 0; Sum1 = 4'd2; Cout1 = 0;
    tick();
    chk("stop_issue_pass", 32'(pass1), 1);
    chk("stop_issue_done", 32'(done1), 1);

    start3 = 1; tick(); start3 = 0;
    for (int i = 0; i < 6; i++) begin
      Mode = 1; Oper = 2'b01; A = ta[i]; B = tb[i]; Cin = tc[i];
      iv3 = 1; r_sum = ts[i]; r_cout = tco[i];
      stop3 = (i == 5);
      tick();
    end
    iv3 = 0; stop3 = 0;
    chk("b2b_busy", 32'(busy3), 1);
    chk("b2b_done0", 32'(done3), 0);
    tick();
    chk("b2b_done1", 32'(done3), 0);
    tick();
    chk("b2b_done2", 32'(done3), 0);
    tick();
    chk("b2b_done3", 32'(done3), 1);
    chk("b2b_pass", 32'(pass3), 6);
    chk("b2b_fail", 32'(fail3), 0);

    start3 = 1; tick(); start3 = 0;
    chk("sat_clear", 32'(pass3), 0);
    for (int i = 0; i < 9; i++) begin
      Mode = 1; Oper = 2'b00; A = 4'd5; B = 4'd9; iv3 = 1; r_sum = 4'd5; r_cout = 0;
      tick();
    end
    iv3 = 0; stop3 = 1; tick(); stop3 = 0;
    for (int k = 0; k < 10 && !done3; k++) tick();
    chk("sat_done", 32'(done3), 1);
    chk("sat_pass", 32'(pass3), 7);
    chk("sat_fail", 32'(fail3), 0);

    start3 = 1; tick(); start3 = 0;
    for (int i = 0; i < 3; i++) begin
      Mode = 1; Oper = 2'b00; A = 4'd6; iv3 = 1; r_sum = 4'd6; r_cout = 0;
      tick();
    end
    iv3 = 0;
    tick();
    chk("pre_rst_pass", 32'(pass3), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pass", 32'(pass3), 0);
    chk("async_rst_busy", 32'(busy3), 0);
    chk("async_rst_done", 32'(done3), 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Sum1 = 4'(i); Cout1 = i[0];
      tick();
    end
    chk("post_rst_pass", 32'(pass3), 0);
    chk("post_rst_fail", 32'(fail3), 0);
    chk("post_rst_busy", 32'(busy3), 0);
    chk("post_rst_pass1", 32'(pass1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
